// File: rtl/jtag_pkg.sv
// Shared JTAG TAP types: state encoding, instruction codes and escape count.
// No ports; imported by jtag_tap_fsm and jtag_tap.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    SEL_IR = 4'd3,
    CAP_DR = 4'd4,
    CAP_IR = 4'd5,
    SH_DR  = 4'd6,
    SH_IR  = 4'd7,
    EX1_DR = 4'd8,
    EX1_IR = 4'd9,
    PAU_DR = 4'd10,
    PAU_IR = 4'd11,
    EX2_DR = 4'd12,
    EX2_IR = 4'd13,
    UPD_DR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  // Codes are truncated to IR_WIDTH; BYPASS is all-ones at any width.
  localparam logic [7:0] INSTR_BYPASS = 8'hFF;
  localparam logic [7:0] INSTR_IDCODE = 8'h01;
  localparam logic [7:0] INSTR_USER   = 8'h02;

  // tms=1 edges that reach TLR from any state.
  localparam int TLR_ESCAPE = 5;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine.
// Ports: tck clock, trst async active-low reset, tms select in, state out.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state <= TLR;
    end else begin
      unique case (state)
        TLR:    state <= tms ? TLR    : RTI;
        RTI:    state <= tms ? SEL_DR : RTI;
        SEL_DR: state <= tms ? SEL_IR : CAP_DR;
        SEL_IR: state <= tms ? TLR    : CAP_IR;
        CAP_DR: state <= tms ? EX1_DR : SH_DR;
        CAP_IR: state <= tms ? EX1_IR : SH_IR;
        SH_DR:  state <= tms ? EX1_DR : SH_DR;
        SH_IR:  state <= tms ? EX1_IR : SH_IR;
        EX1_DR: state <= tms ? UPD_DR : PAU_DR;
        EX1_IR: state <= tms ? UPD_IR : PAU_IR;
        PAU_DR: state <= tms ? EX2_DR : PAU_DR;
        PAU_IR: state <= tms ? EX2_IR : PAU_IR;
        EX2_DR: state <= tms ? UPD_DR : SH_DR;
        EX2_IR: state <= tms ? UPD_IR : SH_IR;
        UPD_DR: state <= tms ? SEL_DR : RTI;
        UPD_IR: state <= tms ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP: IR, BYPASS/IDCODE/USER data registers, negedge tdo.
// Ports: tck, trst(n), tms, tdi, tdo, tdo_en, tap_state, ir_out,
//   user_dr_out, user_dr_in, user_update. Macro JTAG_IDCODE_EN adds IDCODE.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH      = 4,
  parameter int          USER_DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1000_563D
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_out,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic                     user_update
);

  if (IR_WIDTH < 2 || IR_WIDTH > 8)
    $error("IR_WIDTH out of range");
  if (USER_DR_WIDTH < 1 || USER_DR_WIDTH > 32)
    $error("USER_DR_WIDTH out of range");
  if (IDCODE_VALUE[0] != 1'b1)
    $error("IDCODE_VALUE bit 0 must be 1");

  localparam logic [IR_WIDTH-1:0] BYPASS_CODE =
    INSTR_BYPASS[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IDCODE_CODE =
    INSTR_IDCODE[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] USER_CODE =
    INSTR_USER[IR_WIDTH-1:0];
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE =
    IR_WIDTH'(1);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] DEFAULT_IR = IDCODE_CODE;
`else
  localparam logic [IR_WIDTH-1:0] DEFAULT_IR = BYPASS_CODE;
`endif

  tap_state_t state;

  jtag_tap_fsm u_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tms),
    .state (state)
  );

  assign tap_state = state;

  logic [IR_WIDTH-1:0]      ir_sr;
  logic [IR_WIDTH-1:0]      ir_q;
  logic                     bypass_sr;
  logic [USER_DR_WIDTH-1:0] user_sr;
  dr_sel_t                  dr_sel;
  logic                     dr_lsb;

  // Extra top bit lets width-1 registers shift without an empty slice.
  logic [IR_WIDTH:0]        ir_ext;
  logic [USER_DR_WIDTH:0]   user_ext;

  assign ir_ext   = {tdi, ir_sr};
  assign user_ext = {tdi, user_sr};
  assign ir_out   = ir_q;

  always_comb begin
    dr_sel = DR_BYPASS;
    unique case (1'b1)
      (ir_q == USER_CODE):   dr_sel = DR_USER;
`ifdef JTAG_IDCODE_EN
      (ir_q == IDCODE_CODE): dr_sel = DR_IDCODE;
`endif
      default:               dr_sel = DR_BYPASS;
    endcase
  end

  // IR latch follows TLR entry as well as Update-IR.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr <= '0;
      ir_q  <= DEFAULT_IR;
    end else begin
      if (state == CAP_IR)
        ir_sr <= IR_CAPTURE;
      else if (state == SH_IR)
        ir_sr <= ir_ext[IR_WIDTH:1];
      if (state == UPD_IR)
        ir_q <= ir_sr;
      else if (state == TLR || (state == SEL_IR && tms))
        ir_q <= DEFAULT_IR;
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_sr <= 1'b0;
      user_sr   <= '0;
    end else begin
      if (dr_sel == DR_BYPASS) begin
        if (state == CAP_DR)
          bypass_sr <= 1'b0;
        else if (state == SH_DR)
          bypass_sr <= tdi;
      end
      if (dr_sel == DR_USER) begin
        if (state == CAP_DR)
          user_sr <= user_dr_in;
        else if (state == SH_DR)
          user_sr <= user_ext[USER_DR_WIDTH:1];
      end
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      id_sr <= '0;
    end else if (dr_sel == DR_IDCODE) begin
      if (state == CAP_DR)
        id_sr <= IDCODE_VALUE;
      else if (state == SH_DR)
        id_sr <= {tdi, id_sr[31:1]};
    end
  end
`endif

  always_comb begin
    dr_lsb = bypass_sr;
    unique case (dr_sel)
      DR_USER:   dr_lsb = user_sr[0];
`ifdef JTAG_IDCODE_EN
      DR_IDCODE: dr_lsb = id_sr[0];
`endif
      default:   dr_lsb = bypass_sr;
    endcase
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= (state == UPD_DR) && (dr_sel == DR_USER);
      if (state == UPD_DR && dr_sel == DR_USER)
        user_dr_out <= user_sr;
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_DR) || (state == SH_IR);
      if (state == SH_IR)
        tdo <= ir_sr[0];
      else if (state == SH_DR)
        tdo <= dr_lsb;
      else
        tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: directed scans plus random tms/tdi
// walk against a table-and-queue reference model.
`timescale 1ns/1ps
module tb_jtag_tap;
  import jtag_pkg::TLR_ESCAPE;

  localparam int          IRW = 4;
  localparam int          UW  = 8;
  localparam logic [31:0] IDV = 32'h1000_563D;
`ifdef JTAG_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam int DEF_IR = ID_EN ? 1 : (1 << IRW) - 1;

  logic          tck  = 1'b0;
  logic          trst = 1'b1;
  logic          tms  = 1'b1;
  logic          tdi  = 1'b0;
  logic [UW-1:0] user_dr_in = '0;
  logic          tdo, tdo_en, user_update;
  logic [3:0]    tap_state;
  logic [IRW-1:0] ir_out;
  logic [UW-1:0] user_dr_out;

  always #5 tck = ~tck;

  jtag_tap #(
    .IR_WIDTH      (IRW),
    .USER_DR_WIDTH (UW),
    .IDCODE_VALUE  (IDV)
  ) dut (
    .tck         (tck),
    .trst        (trst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .tap_state   (tap_state),
    .ir_out      (ir_out),
    .user_dr_out (user_dr_out),
    .user_dr_in  (user_dr_in),
    .user_update (user_update)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: standard transition table, queues for registers.
  int nx0[16] = '{1, 1, 4, 5, 6, 7, 6, 7, 10, 11, 10, 11, 6, 7, 1, 1};
  int nx1[16] = '{0, 2, 3, 0, 8, 9, 8, 9, 14, 15, 12, 13, 14, 15, 2, 2};
  int m_st, m_ir;
  bit m_irq[$];
  bit m_drq[$];
  logic [UW-1:0] m_udo;
  bit m_upd;
  bit last_tdo;

  function automatic int sel_of(int code);
    if (code == (1 << IRW) - 1) return 0;
    if (code == 1 && ID_EN) return 1;
    if (code == 2) return 2;
    return 0;
  endfunction

  function automatic int q2int(bit q[$]);
    int v = 0;
    foreach (q[i]) v |= int'(q[i]) << i;
    return v;
  endfunction

  function automatic void m_reset();
    m_st = 0;
    m_ir = DEF_IR;
    m_irq = {};
    m_drq = {};
    repeat (IRW) m_irq.push_back(1'b0);
    m_drq.push_back(1'b0);
    m_udo = '0;
    m_upd = 1'b0;
  endfunction

  function automatic void m_edge(bit m, bit d);
    int s = m_st;
    int sel = sel_of(m_ir);
    int v;
    m_upd = (s == 14 && sel == 2);
    case (s)
      5: begin
        m_irq = {};
        m_irq.push_back(1'b1);
        repeat (IRW - 1) m_irq.push_back(1'b0);
      end
      7: begin
        void'(m_irq.pop_front());
        m_irq.push_back(d);
      end
      15: m_ir = q2int(m_irq);
      4: begin
        m_drq = {};
        if (sel == 0) m_drq.push_back(1'b0);
        else if (sel == 1) for (int i = 0; i < 32; i++) m_drq.push_back(IDV[i]);
        else for (int i = 0; i < UW; i++) m_drq.push_back(user_dr_in[i]);
      end
      6: begin
        void'(m_drq.pop_front());
        m_drq.push_back(d);
      end
      14: if (sel == 2) begin
        v = q2int(m_drq);
        m_udo = v[UW-1:0];
      end
      default: ;
    endcase
    if (s == 0 || (s == 3 && m)) m_ir = DEF_IR;
    m_st = m ? nx1[s] : nx0[s];
  endfunction

  task automatic step(input bit m, input bit d);
    bit e_tdo;
    tms = m;
    tdi = d;
    @(posedge tck);
    m_edge(m, d);
    #1;
    chk("tap_state", 32'(tap_state), m_st);
    chk("ir_out", 32'(ir_out), m_ir);
    chk("user_dr_out", 32'(user_dr_out), 32'(m_udo));
    chk("user_update", 32'(user_update), 32'(m_upd));
    @(negedge tck);
    #1;
    e_tdo = (m_st == 6) ? m_drq[0] : (m_st == 7) ? m_irq[0] : 1'b0;
    chk("tdo_en", 32'(tdo_en), 32'(m_st == 6 || m_st == 7));
    chk("tdo", 32'(tdo), 32'(e_tdo));
    last_tdo = tdo;
  endtask

  task automatic do_reset();
    trst = 1'b0;
    #1;
    m_reset();
    chk("rst_state", 32'(tap_state), 0);
    chk("rst_ir", 32'(ir_out), DEF_IR);
    chk("rst_tdo_en", 32'(tdo_en), 0);
    chk("rst_tdo", 32'(tdo), 0);
    chk("rst_udo", 32'(user_dr_out), 0);
    chk("rst_upd", 32'(user_update), 0);
    #1;
    trst = 1'b1;
    last_tdo = 1'b0;
  endtask

  task automatic goto_rti();
    repeat (TLR_ESCAPE) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input int code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < IRW; i++)
      step(i == IRW - 1, 1'((code >> i) & 1));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: scan n bits, optional pause before bit pause_at.
  task automatic scan_dr(input int n, input logic [63:0] din,
                         input int pause_at, output logic [63:0] dout);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = last_tdo;
      if (i == n - 1) begin
        step(1'b1, din[i]);
      end else if (i == pause_at) begin
        step(1'b1, din[i]);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
      end else begin
        step(1'b0, din[i]);
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  int plen[16] = '{3, 0, 1, 2, 2, 3, 3, 4, 3, 4, 4, 5, 5, 6, 4, 5};
  int pbit[16] = '{7, 0, 1, 3, 1, 3, 1, 3, 5, 11, 5, 11, 21, 43, 13, 27};

  initial begin
    logic [63:0] din, dout;
    int code, n;
    m_reset();
    #2;
    do_reset();
    trst = 1'b0;
    @(negedge tck);
    #1;
    trst = 1'b1;

    // IDCODE (or bypass) straight out of reset.
    din = {32'h0, $urandom};
    step(1'b0, 1'b0);
    scan_dr(32, din, -1, dout);
    chk("idcode_or_bypass", dout[31:0],
        ID_EN ? IDV : {din[30:0], 1'b0});
    chk("first_tdo_bit", 32'(dout[0]), ID_EN ? 1 : 0);

    // Explicit BYPASS: one-bit delay.
    load_ir(15);
    scan_dr(4, 64'b1101, -1, dout);
    chk("bypass_1bit", 32'(dout[3:0]), 32'hA);

    // USER capture, shift and update.
    user_dr_in = 8'hA5;
    load_ir(2);
    scan_dr(8, 64'h3C, -1, dout);
    chk("user_capture", 32'(dout[7:0]), 32'hA5);
    chk("user_dr_out", 32'(user_dr_out), 32'h3C);
    chk("user_update_hi", 32'(user_update), 1);
    step(1'b0, 1'b0);
    chk("user_update_lo", 32'(user_update), 0);

    // TLR via tms keeps user_dr_out but restores the default IR.
    repeat (TLR_ESCAPE) step(1'b1, 1'b0);
    chk("tlr_state", 32'(tap_state), 0);
    chk("tlr_ir", 32'(ir_out), DEF_IR);
    chk("tlr_udo_kept", 32'(user_dr_out), 32'h3C);

    // Asynchronous reset in the middle of a USER shift.
    step(1'b0, 1'b0);
    load_ir(2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b0);
    chk("post_rst_udo", 32'(user_dr_out), 0);

    // Escape to TLR from every state.
    for (int t = 0; t < 16; t++) begin
      goto_rti();
      for (int i = 0; i < plen[t]; i++)
        step(1'((pbit[t] >> i) & 1), 1'b0);
      chk("escape_reach", 32'(tap_state), t);
      repeat (TLR_ESCAPE) step(1'b1, 1'($urandom));
      chk("escape_tlr", 32'(tap_state), 0);
    end

    // Random register transactions, some longer than the register.
    goto_rti();
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: code = 1;
        1: code = 2;
        2: code = 15;
        default: code = int'($urandom_range(0, 15));
      endcase
      user_dr_in = UW'($urandom);
      load_ir(code);
      n = int'($urandom_range(1, 40));
      din = {$urandom, $urandom};
      scan_dr(n, din, ($urandom_range(0, 1) == 1) ?
              int'($urandom_range(0, 39)) : -1, dout);
    end

    // Unconstrained tms/tdi walk with occasional async reset.
    repeat (1500) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if ($urandom_range(0, 31) == 0) user_dr_in = UW'($urandom);
      step($urandom_range(0, 99) < 30, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, meaning instruction register width (legal range 2..8).
REQ-002 SHALL have parameter USER_DR_WIDTH, default 8, meaning user data register width (legal range 1..32).
REQ-003 SHALL have parameter IDCODE_VALUE, default 32'h1000_563D, meaning 32-bit device ID; bit 0 SHALL be 1.
REQ-004 SHALL have port tck, input, 1, the only clock.
REQ-005 SHALL have port trst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tms, input, 1, test mode select, sampled on rising tck.
REQ-007 SHALL have port tdi, input, 1, serial data in, sampled on rising tck.
REQ-008 SHALL have port tdo, output, 1, serial data out, updated on falling tck.
REQ-009 SHALL have port tdo_en, output, 1, high while tdo carries valid shift data.
REQ-010 SHALL have port tap_state, output, 4, current TAP state encoding.
REQ-011 SHALL have port ir_out, output, IR_WIDTH, currently latched instruction.
REQ-012 SHALL have port user_dr_out, output, USER_DR_WIDTH, parallel user register, loaded at Update-DR.
REQ-013 SHALL have port user_dr_in, input, USER_DR_WIDTH, parallel value captured at Capture-DR.
REQ-014 SHALL have port user_update, output, 1, one-cycle pulse on the rising tck that leaves Update-DR while USER is selected.

Function
REQ-015 TAP state machine SHALL implement all 16 IEEE 1149.1 states, encoded 0..15: TLR=0, RTI=1, SelDR=2, SelIR=3, CapDR=4, CapIR=5, ShDR=6, ShIR=7, Ex1DR=8, Ex1IR=9, PauDR=10, PauIR=11, Ex2DR=12, Ex2IR=13, UpdDR=14, UpdIR=15; transitions per the standard on rising tck.
REQ-016 Five consecutive tck rising edges with tms=1 SHALL reach TLR from any state.
REQ-017 Instruction decode: all-ones = BYPASS, 1 = IDCODE, 2 = USER; every other code SHALL select BYPASS.
REQ-018 CapIR SHALL load the IR shift register with 'b0...01 (LSB=1, bit1=0, rest 0).
REQ-019 ShIR SHALL shift right: tdi enters MSB, LSB drives tdo; IR latch SHALL update only on leaving UpdIR.
REQ-020 CapDR SHALL load selected DR: BYPASS=0, IDCODE=IDCODE_VALUE, USER=user_dr_in.
REQ-021 ShDR SHALL shift the selected DR right, tdi into MSB, LSB to tdo; BYPASS length SHALL be exactly 1.
REQ-022 Leaving UpdDR with USER selected SHALL load user_dr_out from the shift register and pulse user_update; no other instruction SHALL alter user_dr_out.
REQ-023 tdo and tdo_en SHALL be registered on falling tck; tdo_en=1 only in ShDR/ShIR, else tdo=0.
REQ-024 Pause and Exit states SHALL hold shift register contents unchanged.
REQ-025 Shift length longer than register SHALL continue shifting (tdi value emerges after register-length cycles); no wrap or saturation.

Reset
REQ-026 trst low SHALL immediately force tap_state=TLR, IR latch to default instruction, all shift registers 0, user_dr_out=0, user_update=0, tdo=0, tdo_en=0, independent of tck.
REQ-027 Entering TLR via tms SHALL reload IR latch with default instruction but SHALL NOT clear user_dr_out.
REQ-028 trst asserted mid-shift SHALL discard partial shift data; no Update effects.

Configuration
REQ-029 Macro JTAG_IDCODE_EN defined: IDCODE register present, default instruction = IDCODE.
REQ-030 Macro JTAG_IDCODE_EN undefined: no IDCODE register; code 1 decodes to BYPASS; default instruction = BYPASS.

Structure
REQ-031 Package jtag_pkg SHALL hold the 4-bit state typedef/enum, instruction code constants (BYPASS/IDCODE/USER) and the TLR-escape count (5).
REQ-032 State machine SHALL be a sub-module jtag_tap_fsm (tck, trst, tms in; state out); data registers live in jtag_tap.

Verification
REQ-033 trst low for 1 ns mid-ShDR -> tap_state=0, ir_out=1, tdo_en=0 before next tck edge.
REQ-034 From RTI, tms=1 for 5 tck -> tap_state=0; repeated from every one of 16 states.
REQ-035 Reset, tms 0,1,0,0 then shift 32 bits -> tdo sequence equals IDCODE_VALUE LSB first (0x1000563D).
REQ-036 Load IR=4'hF, shift DR with tdi pattern 1,0,1,1 -> tdo shows 0,1,0,1 (1-bit delay).
REQ-037 Load IR=2, user_dr_in=8'hA5, shift in 8'h3C -> tdo yields 8'hA5 LSB first; after UpdDR user_dr_out=8'h3C, user_update high one cycle.
REQ-038 Build without JTAG_IDCODE_EN, reset, shift DR -> 1-bit BYPASS path, first tdo bit 0.
